if_fetch: RTL

//  Instruction-fetch stage plus IF/ID pipeline register of the 16-bit MIPS16 core; feeds pc/inst to id.

---
 rtl/if_fetch.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage and IF/ID pipeline register of the 16-bit MIPS16 core.
// Optional feature macro: DELAY_SLOT_EN (the instruction after a taken branch executes).
module if_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [15:0] branch_addr_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_data_i,
    output logic [15:0] pc_o,
    output logic [15:0] inst_o,
    output logic        valid_o,
    output logic        stall_req_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] skid_pc_q, skid_pc_d;
    logic [15:0] skid_inst_q, skid_inst_d;
    logic [15:0] pc_o_q, pc_o_d;
    logic [15:0] inst_o_q, inst_o_d;
    logic        valid_q, valid_d;
    logic        branch_take_s;
    logic [15:0] next_pc_s;
`ifdef DELAY_SLOT_EN
    logic        redir_pend_q, redir_pend_d;
    logic [15:0] redir_addr_q, redir_addr_d;
    logic        slot_done_s;
`endif

    // The request and address are decoded from registered state only.
    assign imem_req_o  = (state_q == ST_FETCH);
    assign imem_addr_o = (state_q == ST_FETCH) ? pc_q : 16'h0000;
    assign stall_req_o = (state_q == ST_FETCH) && !imem_ack_i;
    assign pc_o        = pc_o_q;
    assign inst_o      = inst_o_q;
    assign valid_o     = valid_q;

    // Next-state, PC and IF/ID register update.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        skid_pc_d     = skid_pc_q;
        skid_inst_d   = skid_inst_q;
        pc_o_d        = pc_o_q;
        inst_o_d      = inst_o_q;
        valid_d       = valid_q;
        branch_take_s = branch_flag_i && !stall_i && valid_q;
`ifdef DELAY_SLOT_EN
        redir_pend_d  = redir_pend_q;
        redir_addr_d  = redir_addr_q;
        slot_done_s   = 1'b0;
        next_pc_s     = redir_pend_q ? redir_addr_q : (pc_q + 16'h0001);
`else
        next_pc_s     = pc_q + 16'h0001;
`endif

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack_i) begin
                    pc_d = next_pc_s;
`ifdef DELAY_SLOT_EN
                    redir_pend_d = 1'b0;
`endif
                    if (stall_i) begin
                        skid_pc_d   = pc_q;
                        skid_inst_d = imem_data_i;
                        state_d     = ST_HOLD;
                    end else begin
                        pc_o_d   = pc_q;
                        inst_o_d = imem_data_i;
                        valid_d  = 1'b1;
`ifdef DELAY_SLOT_EN
                        slot_done_s = 1'b1;
`endif
                    end
                end else if (!stall_i) begin
                    valid_d  = 1'b0;
                    inst_o_d = NOP_INST;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    pc_o_d   = skid_pc_q;
                    inst_o_d = skid_inst_q;
                    valid_d  = 1'b1;
                    state_d  = ST_FETCH;
`ifdef DELAY_SLOT_EN
                    slot_done_s = 1'b1;
`endif
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

`ifdef DELAY_SLOT_EN
        // A branch whose slot word is not yet delivered is parked until that word's ack.
        if (branch_take_s) begin
            if (slot_done_s) begin
                pc_d = branch_addr_i;
            end else begin
                redir_pend_d = 1'b1;
                redir_addr_d = branch_addr_i;
            end
        end else begin
            redir_pend_d = redir_pend_d;
        end
`else
        // Squash: the younger word (ack data or skid) is dropped and fetch restarts at the target.
        if (branch_take_s) begin
            valid_d  = 1'b0;
            inst_o_d = NOP_INST;
            pc_d     = branch_addr_i;
            state_d  = ST_FETCH;
        end else begin
            pc_d = pc_d;
        end
`endif
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            skid_pc_q    <= 16'h0000;
            skid_inst_q  <= NOP_INST;
            pc_o_q       <= 16'h0000;
            inst_o_q     <= NOP_INST;
            valid_q      <= 1'b0;
`ifdef DELAY_SLOT_EN
            redir_pend_q <= 1'b0;
            redir_addr_q <= 16'h0000;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
            pc_o_q       <= pc_o_d;
            inst_o_q     <= inst_o_d;
            valid_q      <= valid_d;
`ifdef DELAY_SLOT_EN
            redir_pend_q <= redir_pend_d;
            redir_addr_q <= redir_addr_d;
`endif
        end
    end

endmodule
